fm_bank_loader: RTL
===================

Name: fm_bank_loader

Overview:
- Synthesizable loader that replaces behavioural BRAM preloading ahead of layer_blk.
- Accepts one valid/ready word stream carrying the kernel weights, then the input feature map, channel by channel in raster order.
- Writes weights into the per-output-channel weight BRAMs.
- Splits each input channel into NUM_PE row banks. Overlap rows (KERNEL_SIZE-STRIDE) are written to both neighbouring banks in the same cycle.
- Pulses o_done when every bank is written, so the conv block can start.

Parameters:
- DATA_W, 30, FM pixel width and stream width.
- W_DATA_W, 18, weight width; taken from i_s_data[W_DATA_W-1:0].
- FM_SIZE, 252, FM width and height in pixels.
- KERNEL_SIZE, 3, kernel edge.
- STRIDE, 1, conv stride; must be less than KERNEL_SIZE.
- IN_FM_CH, 3, input channels.
- OUT_FM_CH, 2, output channels (number of weight BRAMs).
- NUM_PE, 4, row banks per input channel.
- BANK_ROWS, 65, rows per bank including overlap.
- OVL (localparam), KERNEL_SIZE-STRIDE.
- ROW_STEP (localparam), BANK_ROWS-OVL.
- Legality: OVL <= ROW_STEP, and FM_SIZE <= (NUM_PE-1)*ROW_STEP+BANK_ROWS. Both are checked at elaboration with $error.
- FA_W (localparam), $clog2(BANK_ROWS*FM_SIZE).
- WA_W (localparam), $clog2(KERNEL_SIZE**2)+1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle start pulse; honoured only in IDLE.
- i_s_data  in  DATA_W  stream word.
- i_s_valid  in  1  stream word valid.
- o_s_ready  out  1  loader accepts a word.
- o_wt_w_en  out  OUT_FM_CH  one-hot weight BRAM write enable.
- o_wt_w_addr  out  WA_W  weight address, 0..KERNEL_SIZE**2-1.
- o_wt_w_data  out  W_DATA_W  weight data.
- o_fm_w_en  out  IN_FM_CH*NUM_PE  FM bank write enables; bit index is ch*NUM_PE+bank.
- o_fm_w_addr  out  FA_W  address for the primary bank.
- o_fm_w_addr_ovl  out  FA_W  address for the overlap bank (bank+1).
- o_fm_w_data  out  DATA_W  pixel, shared by both banks.
- o_busy  out  1  high from start accept until o_done.
- o_done  out  1  one-cycle pulse.

Behaviour:
- Reset (async, i_rst=0): FSM goes to IDLE and all counters clear. All outputs are 0.
- Reset mid-load: all writes abort at once. No o_done is produced. A new i_start is required.
- FSM states: IDLE, LOAD_WT, LOAD_FM, FINISH.
  - IDLE -> LOAD_WT on i_start.
  - LOAD_WT -> LOAD_FM on acceptance of the last weight, OUT_FM_CH*KERNEL_SIZE**2 beats in total.
  - LOAD_FM -> FINISH on acceptance of the last pixel, IN_FM_CH*FM_SIZE**2 beats.
  - FINISH -> IDLE after one cycle, with o_done=1 in that cycle.
- Handshake:
  - o_s_ready = 1 in LOAD_WT and LOAD_FM, 0 otherwise.
  - A beat is accepted when valid&&ready. Gaps in valid stall the counters.
  - Data offered while not ready is ignored.
- Write latency: every accepted beat produces registered write outputs exactly one cycle later. Enables are 0 in all other cycles.
- The last FM write and o_done are in the same cycle.
- Weight order: output channel major, then k = 0..KERNEL_SIZE**2-1. Beat gives o_wt_w_en = 1<<och and o_wt_w_addr = k.
- FM order: channel major, then row, then column. Counters are col, row, ch, bank and lrow (local row).
  - Bank tracking is incremental, with no divider.
  - Every FM beat writes the primary bank: bit ch*NUM_PE+bank, with o_fm_w_addr = lrow*FM_SIZE+col.
  - If lrow >= ROW_STEP and bank < NUM_PE-1, bit ch*NUM_PE+bank+1 is also set, with o_fm_w_addr_ovl = (lrow-ROW_STEP)*FM_SIZE+col. Otherwise o_fm_w_addr_ovl = 0.
- Counter wrap:
  - col wraps at FM_SIZE-1 and advances the row.
  - On a row advance, lrow increments. If lrow reaches BANK_ROWS, then bank increments and lrow becomes OVL.
  - row wrap at FM_SIZE-1 clears bank and lrow and advances ch.
- Rows past the end of the last bank cannot occur, because of the legality check.
- i_start while busy is ignored.
- Address arithmetic is unsigned. Products use a multiply by a constant FM_SIZE, or an incrementally maintained base register.

Decomposition:
- Shared package holds:
  - the legality check function;
  - localparams OVL, ROW_STEP, FA_W, WA_W;
  - the state enum {IDLE, LOAD_WT, LOAD_FM, FINISH}.
- One natural sub-module, fm_raster_cnt: col/row/ch/bank/lrow counters with an advance input. It outputs the primary and overlap addresses plus bank and last flags.

Test Plan:
Tests use FM_SIZE=8, KERNEL_SIZE=3, STRIDE=1, IN_FM_CH=3, OUT_FM_CH=2, NUM_PE=3, BANK_ROWS=4. Banks then cover rows 0-3, 2-5 and 4-7.
- Weights: start, then 18 beats with valid held high, data=beat index.
  -> Beat 9 gives o_wt_w_en=2'b10, addr 0, data 9, one cycle after acceptance.
  -> Beat 17 gives addr 8.
- Overlap split: ch0, row 3, col 5, data 0x1D5.
  -> o_fm_w_en bits 0 and 1 set, addr 29, addr_ovl 13.
  -> ch0 row 4 col 0 gives bits 1 and 2 set, addr 16, addr_ovl 0.
- Last bank tail: ch2, row 7, col 7.
  -> Only bit 8 set, addr 31, addr_ovl 0.
  -> o_done high in the same cycle; o_busy falls next cycle; total FM beats 192.
- Backpressure: random valid at about 30% duty.
  -> Write sequence is identical to the full-rate run; no write occurs in a cycle without a beat accepted the cycle before.
- Reset mid-load: i_rst low after 50 FM beats.
  -> All outputs 0 within the reset assertion.
  -> No o_done; o_s_ready=0 until the next i_start.
  -> A full reload then completes with correct addresses.
- i_start during LOAD_FM: pulse it.
  -> Counters undisturbed; exactly one o_done at the end.

Source files
------------

// File: rtl/fm_bank_loader_pkg.sv
// Shared FSM type and geometry helpers for the FM bank loader and its raster counter.
package fm_bank_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_WT = 2'd1,
        LOAD_FM = 2'd2,
        FINISH  = 2'd3
    } state_e;

    function automatic int calc_ovl(input int kernel_size, input int stride);
        return kernel_size - stride;
    endfunction

    function automatic int calc_row_step(input int bank_rows, input int kernel_size, input int stride);
        return bank_rows - calc_ovl(kernel_size, stride);
    endfunction

    function automatic int calc_fa_w(input int bank_rows, input int fm_size);
        return $clog2(bank_rows * fm_size);
    endfunction

    function automatic int calc_wa_w(input int kernel_size);
        return $clog2(kernel_size * kernel_size) + 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Overlap must fit in one step and the banks together must cover every row.
    function automatic bit cfg_legal(input int fm_size, input int kernel_size, input int stride,
                                     input int num_pe, input int bank_rows);
        int ovl;
        int row_step;
        ovl      = calc_ovl(kernel_size, stride);
        row_step = calc_row_step(bank_rows, kernel_size, stride);
        return (stride < kernel_size) && (ovl <= row_step) &&
               (fm_size <= (num_pe - 1) * row_step + bank_rows);
    endfunction

endpackage

// File: rtl/fm_raster_cnt.sv
// Raster counters for the FM stream: col/row/channel plus incrementally tracked bank and local row,
// with primary and overlap bank addresses derived from the current position.
module fm_raster_cnt
    import fm_bank_loader_pkg::*;
#(
    parameter int FM_SIZE     = 252,
    parameter int KERNEL_SIZE = 3,
    parameter int STRIDE      = 1,
    parameter int IN_FM_CH    = 3,
    parameter int NUM_PE      = 4,
    parameter int BANK_ROWS   = 65,
    parameter int FA_W        = calc_fa_w(BANK_ROWS, FM_SIZE),
    parameter int CH_W        = cnt_w(IN_FM_CH),
    parameter int PE_W        = cnt_w(NUM_PE)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            clr,
    input  logic            adv,
    output logic [FA_W-1:0] addr,
    output logic [FA_W-1:0] addr_ovl,
    output logic            ovl_hit,
    output logic [CH_W-1:0] ch,
    output logic [PE_W-1:0] bank,
    output logic            last
);
    localparam int OVL      = calc_ovl(KERNEL_SIZE, STRIDE);
    localparam int ROW_STEP = calc_row_step(BANK_ROWS, KERNEL_SIZE, STRIDE);
    localparam int COL_W    = cnt_w(FM_SIZE);
    localparam int LROW_W   = cnt_w(BANK_ROWS);

    logic [COL_W-1:0]  col_r;
    logic [COL_W-1:0]  row_r;
    logic [CH_W-1:0]   ch_r;
    logic [PE_W-1:0]   bank_r;
    logic [LROW_W-1:0] lrow_r;
    logic              col_end_s;
    logic              row_end_s;
    logic              ch_end_s;
    logic              lrow_end_s;

    assign col_end_s  = (col_r == COL_W'(FM_SIZE - 1));
    assign row_end_s  = (row_r == COL_W'(FM_SIZE - 1));
    assign ch_end_s   = (ch_r == CH_W'(IN_FM_CH - 1));
    assign lrow_end_s = (lrow_r == LROW_W'(BANK_ROWS - 1));
    assign ch         = ch_r;
    assign bank       = bank_r;
    assign last       = col_end_s && row_end_s && ch_end_s;

    // Counter advance; leaving a bank re-enters the next one at the first non-overlap row.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            col_r  <= {COL_W{1'b0}};
            row_r  <= {COL_W{1'b0}};
            ch_r   <= {CH_W{1'b0}};
            bank_r <= {PE_W{1'b0}};
            lrow_r <= {LROW_W{1'b0}};
        end else if (clr) begin
            col_r  <= {COL_W{1'b0}};
            row_r  <= {COL_W{1'b0}};
            ch_r   <= {CH_W{1'b0}};
            bank_r <= {PE_W{1'b0}};
            lrow_r <= {LROW_W{1'b0}};
        end else if (adv) begin
            if (!col_end_s) begin
                col_r <= col_r + COL_W'(1'b1);
            end else begin
                col_r <= {COL_W{1'b0}};
                if (!row_end_s) begin
                    row_r <= row_r + COL_W'(1'b1);
                    if (lrow_end_s) begin
                        bank_r <= bank_r + PE_W'(1'b1);
                        lrow_r <= LROW_W'(OVL);
                    end else begin
                        lrow_r <= lrow_r + LROW_W'(1'b1);
                    end
                end else begin
                    row_r  <= {COL_W{1'b0}};
                    bank_r <= {PE_W{1'b0}};
                    lrow_r <= {LROW_W{1'b0}};
                    ch_r   <= ch_end_s ? {CH_W{1'b0}} : ch_r + CH_W'(1'b1);
                end
            end
        end
    end

    // Bank addresses; the overlap copy lands ROW_STEP rows earlier in the next bank.
    always_comb begin
        ovl_hit = (lrow_r >= LROW_W'(ROW_STEP)) && (bank_r < PE_W'(NUM_PE - 1));
        addr    = FA_W'(lrow_r) * FA_W'(FM_SIZE) + FA_W'(col_r);
        if (ovl_hit) begin
            addr_ovl = FA_W'(lrow_r - LROW_W'(ROW_STEP)) * FA_W'(FM_SIZE) + FA_W'(col_r);
        end else begin
            addr_ovl = {FA_W{1'b0}};
        end
    end

endmodule

// File: rtl/fm_bank_loader.sv
// Streams weights then the input feature map into weight BRAMs and overlapped FM row banks,
// pulsing o_done once everything is written.
module fm_bank_loader
    import fm_bank_loader_pkg::*;
#(
    parameter int DATA_W      = 30,
    parameter int W_DATA_W    = 18,
    parameter int FM_SIZE     = 252,
    parameter int KERNEL_SIZE = 3,
    parameter int STRIDE      = 1,
    parameter int IN_FM_CH    = 3,
    parameter int OUT_FM_CH   = 2,
    parameter int NUM_PE      = 4,
    parameter int BANK_ROWS   = 65,
    localparam int OVL        = calc_ovl(KERNEL_SIZE, STRIDE),
    localparam int ROW_STEP   = calc_row_step(BANK_ROWS, KERNEL_SIZE, STRIDE),
    localparam int FA_W       = calc_fa_w(BANK_ROWS, FM_SIZE),
    localparam int WA_W       = calc_wa_w(KERNEL_SIZE)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [DATA_W-1:0]            i_s_data,
    input  logic                         i_s_valid,
    output logic                         o_s_ready,
    output logic [OUT_FM_CH-1:0]         o_wt_w_en,
    output logic [WA_W-1:0]              o_wt_w_addr,
    output logic [W_DATA_W-1:0]          o_wt_w_data,
    output logic [IN_FM_CH*NUM_PE-1:0]   o_fm_w_en,
    output logic [FA_W-1:0]              o_fm_w_addr,
    output logic [FA_W-1:0]              o_fm_w_addr_ovl,
    output logic [DATA_W-1:0]            o_fm_w_data,
    output logic                         o_busy,
    output logic                         o_done
);
    localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NB    = IN_FM_CH * NUM_PE;
    localparam int OCH_W = cnt_w(OUT_FM_CH);
    localparam int CH_W  = cnt_w(IN_FM_CH);
    localparam int PE_W  = cnt_w(NUM_PE);
    localparam int BI_W  = cnt_w(NB) + 1;

    if (!cfg_legal(FM_SIZE, KERNEL_SIZE, STRIDE, NUM_PE, BANK_ROWS)) begin : g_bad_cfg
        $error("fm_bank_loader: overlap exceeds row step or banks do not cover FM_SIZE rows");
    end

    state_e                state_r, state_nx_s;
    logic                  ready_r, busy_r, done_r;
    logic                  ready_nx_s, busy_nx_s, done_nx_s;
    logic [OCH_W-1:0]      wt_och_r;
    logic [WA_W-1:0]       wt_k_r;
    logic                  accept_s, start_s, wt_last_s, fm_adv_s;
    logic [FA_W-1:0]       fa_s, fa_ovl_s;
    logic                  ovl_hit_s, fm_last_s;
    logic [CH_W-1:0]       ch_s;
    logic [PE_W-1:0]       bank_s;
    logic [BI_W-1:0]       bidx_s;
    logic [OUT_FM_CH-1:0]  wt_en_nx_s, wt_en_r;
    logic [WA_W-1:0]       wt_addr_nx_s, wt_addr_r;
    logic [W_DATA_W-1:0]   wt_data_nx_s, wt_data_r;
    logic [NB-1:0]         fm_en_nx_s, fm_en_r;
    logic [FA_W-1:0]       fm_addr_nx_s, fm_addr_r, fm_ovl_nx_s, fm_ovl_r;
    logic [DATA_W-1:0]     fm_data_nx_s, fm_data_r;

    assign accept_s  = i_s_valid && ready_r;
    assign start_s   = i_start && (state_r == IDLE);
    assign wt_last_s = (wt_och_r == OCH_W'(OUT_FM_CH - 1)) && (wt_k_r == WA_W'(KK - 1));
    assign fm_adv_s  = accept_s && (state_r == LOAD_FM);
    assign bidx_s    = BI_W'(ch_s) * BI_W'(NUM_PE) + BI_W'(bank_s);

    fm_raster_cnt #(
        .FM_SIZE     (FM_SIZE),
        .KERNEL_SIZE (KERNEL_SIZE),
        .STRIDE      (STRIDE),
        .IN_FM_CH    (IN_FM_CH),
        .NUM_PE      (NUM_PE),
        .BANK_ROWS   (BANK_ROWS),
        .FA_W        (FA_W),
        .CH_W        (CH_W),
        .PE_W        (PE_W)
    ) u_raster (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .clr      (start_s),
        .adv      (fm_adv_s),
        .addr     (fa_s),
        .addr_ovl (fa_ovl_s),
        .ovl_hit  (ovl_hit_s),
        .ch       (ch_s),
        .bank     (bank_s),
        .last     (fm_last_s)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = start_s ? LOAD_WT : IDLE;
            LOAD_WT: state_nx_s = (accept_s && wt_last_s) ? LOAD_FM : LOAD_WT;
            LOAD_FM: state_nx_s = (accept_s && fm_last_s) ? FINISH : LOAD_FM;
            FINISH:  state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Output decode; control flags follow the next state so they register alongside it.
    always_comb begin
        ready_nx_s   = (state_nx_s == LOAD_WT) || (state_nx_s == LOAD_FM);
        busy_nx_s    = (state_nx_s != IDLE);
        done_nx_s    = (state_nx_s == FINISH);
        if (accept_s && (state_r == LOAD_WT)) begin
            wt_en_nx_s   = OUT_FM_CH'(1'b1) << wt_och_r;
            wt_addr_nx_s = wt_k_r;
            wt_data_nx_s = i_s_data[W_DATA_W-1:0];
        end else begin
            wt_en_nx_s   = {OUT_FM_CH{1'b0}};
            wt_addr_nx_s = {WA_W{1'b0}};
            wt_data_nx_s = {W_DATA_W{1'b0}};
        end
        if (fm_adv_s) begin
            fm_en_nx_s   = (NB'(1'b1) << bidx_s) |
                           (ovl_hit_s ? (NB'(1'b1) << (bidx_s + BI_W'(1'b1))) : {NB{1'b0}});
            fm_addr_nx_s = fa_s;
            fm_ovl_nx_s  = fa_ovl_s;
            fm_data_nx_s = i_s_data;
        end else begin
            fm_en_nx_s   = {NB{1'b0}};
            fm_addr_nx_s = {FA_W{1'b0}};
            fm_ovl_nx_s  = {FA_W{1'b0}};
            fm_data_nx_s = {DATA_W{1'b0}};
        end
    end

    // Weight position counters: output channel major, kernel tap minor.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wt_och_r <= {OCH_W{1'b0}};
            wt_k_r   <= {WA_W{1'b0}};
        end else if (start_s) begin
            wt_och_r <= {OCH_W{1'b0}};
            wt_k_r   <= {WA_W{1'b0}};
        end else if (accept_s && (state_r == LOAD_WT)) begin
            if (wt_k_r == WA_W'(KK - 1)) begin
                wt_k_r   <= {WA_W{1'b0}};
                wt_och_r <= wt_last_s ? {OCH_W{1'b0}} : wt_och_r + OCH_W'(1'b1);
            end else begin
                wt_k_r <= wt_k_r + WA_W'(1'b1);
            end
        end
    end

    // Registered outputs: every write appears exactly one cycle after its beat.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wt_en_r   <= {OUT_FM_CH{1'b0}};
            wt_addr_r <= {WA_W{1'b0}};
            wt_data_r <= {W_DATA_W{1'b0}};
            fm_en_r   <= {NB{1'b0}};
            fm_addr_r <= {FA_W{1'b0}};
            fm_ovl_r  <= {FA_W{1'b0}};
            fm_data_r <= {DATA_W{1'b0}};
        end else begin
            ready_r   <= ready_nx_s;
            busy_r    <= busy_nx_s;
            done_r    <= done_nx_s;
            wt_en_r   <= wt_en_nx_s;
            wt_addr_r <= wt_addr_nx_s;
            wt_data_r <= wt_data_nx_s;
            fm_en_r   <= fm_en_nx_s;
            fm_addr_r <= fm_addr_nx_s;
            fm_ovl_r  <= fm_ovl_nx_s;
            fm_data_r <= fm_data_nx_s;
        end
    end

    assign o_s_ready       = ready_r;
    assign o_busy          = busy_r;
    assign o_done          = done_r;
    assign o_wt_w_en       = wt_en_r;
    assign o_wt_w_addr     = wt_addr_r;
    assign o_wt_w_data     = wt_data_r;
    assign o_fm_w_en       = fm_en_r;
    assign o_fm_w_addr     = fm_addr_r;
    assign o_fm_w_addr_ovl = fm_ovl_r;
    assign o_fm_w_data     = fm_data_r;

endmodule
